// File: rtl/apb_master_param_if.sv
// Bundled command, APB and response signals of the APB master.
// The master modport is the RTL view; the slave modport is the environment's view.
interface apb_master_param_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    output cmd_ready, psel, penable, pwrite, paddr, pwdata,
           rsp_valid, rsp_rdata, rsp_err, rsp_timeout
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    input  cmd_ready, psel, penable, pwrite, paddr, pwdata,
           rsp_valid, rsp_rdata, rsp_err, rsp_timeout
  );
endinterface

// File: rtl/apb_master_param.sv
// APB master: one command in, one SETUP/ACCESS transfer out, one registered
// response pulse back; ACCESS is aborted after TIMEOUT wait cycles.
module apb_master_param #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                preset,
  apb_master_param_if.master  bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_timeout;

  logic w_cmd_ready;
  logic w_psel;
  logic w_penable;
  logic w_accept;
  logic w_done;
  logic w_timeout;

  assign w_accept  = bus.cmd_valid & w_cmd_ready;
  assign w_done    = (r_state == ACCESS) & bus.pready;
  assign w_timeout = (r_state == ACCESS) & ~bus.pready &
                     (r_wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = SETUP;
      SETUP:   w_state_next = ACCESS;
      ACCESS: begin
        if (bus.pready)     w_state_next = w_accept ? SETUP : IDLE;
        else if (w_timeout) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // A timeout cycle always has pready low, so it never offers cmd_ready.
  always_comb begin
    w_psel      = (r_state == SETUP) | (r_state == ACCESS);
    w_penable   = (r_state == ACCESS);
    w_cmd_ready = (r_state == IDLE) | ((r_state == ACCESS) & bus.pready);
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
    end else if (w_accept) begin
      r_pwrite <= bus.cmd_write;
      r_paddr  <= bus.cmd_addr;
      r_pwdata <= bus.cmd_write ? bus.cmd_wdata : '0;
    end
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset)
      r_wait_cnt <= '0;
    else if (r_state == SETUP)
      r_wait_cnt <= '0;
    else if ((r_state == ACCESS) && !bus.pready)
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
  end

  // Response fields hold between pulses; only rsp_valid is a strobe.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid <= w_done | w_timeout;
      if (w_done) begin
        r_rsp_rdata   <= r_pwrite ? '0 : bus.prdata;
        r_rsp_err     <= bus.pslverr;
        r_rsp_timeout <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_rdata   <= '0;
        r_rsp_err     <= 1'b1;
        r_rsp_timeout <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready   = w_cmd_ready;
  assign bus.psel        = w_psel;
  assign bus.penable     = w_penable;
  assign bus.pwrite      = r_pwrite;
  assign bus.paddr       = r_paddr;
  assign bus.pwdata      = r_pwdata;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_timeout = r_rsp_timeout;
endmodule

// File: tb/tb_apb_master_param.sv
// Self-checking bench for apb_master_param: directed transfers with an
// expected-response queue consumed by a response monitor.
module tb_apb_master_param;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 4;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
  } rsp_t;

  logic pclk = 1'b0;
  logic preset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_rsp = 0;
  int   n_pushed = 0;
  rsp_t sb_q[$];

  apb_master_param_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master_param #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] rd, input logic err, input logic tmo);
    rsp_t e;
    e.rdata = rd;
    e.err   = err;
    e.tmo   = tmo;
    sb_q.push_back(e);
    n_pushed++;
  endtask

  always @(negedge pclk) begin
    if (bus.rsp_valid) begin
      n_rsp++;
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        rsp_t e;
        e = sb_q.pop_front();
        check("rsp_rdata", bus.rsp_rdata, e.rdata);
        check("rsp_err", bus.rsp_err, e.err);
        check("rsp_timeout", bus.rsp_timeout, e.tmo);
      end
    end
  end

  // Single transfer from IDLE; waits >= TO exercises the timeout abort.
  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int waits, input logic [DW-1:0] rd, input logic err);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    if (waits >= TO)   push_exp('0, 1'b1, 1'b1);
    else if (wr)       push_exp('0, err, 1'b0);
    else               push_exp(rd, err, 1'b0);
    @(negedge pclk);
    check("idle_cmd_ready", bus.cmd_ready, 1);
    @(posedge pclk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = ~wr;
    bus.cmd_addr  = ~a;
    bus.cmd_wdata = ~d;
    @(negedge pclk);
    check("setup_psel", bus.psel, 1);
    check("setup_penable", bus.penable, 0);
    check("setup_paddr", bus.paddr, a);
    check("setup_pwrite", bus.pwrite, wr);
    check("setup_pwdata", bus.pwdata, wr ? d : '0);
    @(posedge pclk); #1;
    for (int i = 0; i < waits && i < TO; i++) begin
      bus.pready  = 1'b0;
      bus.pslverr = 1'b1;
      @(negedge pclk);
      check("wait_penable", bus.penable, 1);
      check("wait_paddr", bus.paddr, a);
      check("wait_cmd_ready", bus.cmd_ready, 0);
      @(posedge pclk); #1;
    end
    if (waits < TO) begin
      bus.pready  = 1'b1;
      bus.pslverr = err;
      bus.prdata  = rd;
      @(negedge pclk);
      check("access_penable", bus.penable, 1);
      check("access_paddr", bus.paddr, a);
      check("access_cmd_ready", bus.cmd_ready, 1);
      @(posedge pclk); #1;
    end
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    @(negedge pclk);
    check("end_psel", bus.psel, 0);
    check("end_rsp_valid", bus.rsp_valid, 1);
    @(posedge pclk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    #12;
    check("rst_psel", bus.psel, 0);
    check("rst_penable", bus.penable, 0);
    check("rst_paddr", bus.paddr, 0);
    check("rst_pwdata", bus.pwdata, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    @(posedge pclk); #1;
    preset = 1'b1;
    @(posedge pclk); #1;

    xfer(1'b1, 8'h12, 8'hA5, 0, 8'h00, 1'b0);   // write, zero wait
    xfer(1'b0, 8'h40, 8'h77, 3, 8'h3C, 1'b0);   // read, 3 waits
    xfer(1'b0, 8'h33, 8'h00, 0, 8'h5A, 1'b1);   // slave error read
    @(negedge pclk);
    check("rsp_hold_rdata", bus.rsp_rdata, 8'h5A);
    check("rsp_hold_err", bus.rsp_err, 1);
    @(posedge pclk); #1;
    xfer(1'b0, 8'h44, 8'h00, TO, 8'hFF, 1'b0);  // timeout

    // Back-to-back: second command waits through SETUP, accepted in ACCESS
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 8'h20;
    bus.cmd_wdata = 8'h11;
    push_exp('0, 1'b0, 1'b0);
    @(posedge pclk); #1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h21;
    bus.cmd_wdata = 8'hEE;
    @(negedge pclk);
    check("b2b_setup1_paddr", bus.paddr, 8'h20);
    check("b2b_setup1_ready", bus.cmd_ready, 0);
    @(posedge pclk); #1;
    bus.pready = 1'b1;
    bus.prdata = 8'h99;
    @(negedge pclk);
    check("b2b_access1_ready", bus.cmd_ready, 1);
    push_exp(8'h77, 1'b0, 1'b0);
    @(posedge pclk); #1;
    bus.cmd_valid = 1'b0;
    bus.prdata = 8'h77;
    @(negedge pclk);
    check("b2b_setup2_psel", bus.psel, 1);
    check("b2b_setup2_penable", bus.penable, 0);
    check("b2b_setup2_paddr", bus.paddr, 8'h21);
    check("b2b_setup2_pwdata", bus.pwdata, 0);
    check("b2b_pulse1", bus.rsp_valid, 1);
    @(posedge pclk); #1;
    @(negedge pclk);
    check("b2b_gap", bus.rsp_valid, 0);
    @(posedge pclk); #1;
    bus.pready = 1'b0;
    @(negedge pclk);
    check("b2b_pulse2", bus.rsp_valid, 1);
    check("b2b_idle", bus.psel, 0);
    @(posedge pclk); #1;

    xfer(1'b0, 8'h66, 8'h00, 1, 8'hC3, 1'b0);

    // Reset in the middle of ACCESS: no response may follow
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h55;
    @(posedge pclk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge pclk); #1;
    bus.pready = 1'b0;
    @(negedge pclk);
    check("pre_rst_penable", bus.penable, 1);
    #2;
    preset = 1'b0;
    #1;
    check("arst_psel", bus.psel, 0);
    check("arst_penable", bus.penable, 0);
    check("arst_paddr", bus.paddr, 0);
    check("arst_rsp_rdata", bus.rsp_rdata, 0);
    repeat (2) @(posedge pclk);
    #1;
    preset = 1'b1;
    @(negedge pclk);
    check("post_rst_ready", bus.cmd_ready, 1);
    repeat (5) @(posedge pclk);
    #1;
    check("sb_empty", sb_q.size(), 0);
    check("rsp_count", n_rsp, n_pushed);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
